// File: rtl/fetch_pkg.sv
// Shared types and field bounds for the instruction fetch stage.
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERROR} fetch_state_e;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int JT_HI  = 25;
   localparam int JT_LO  = 0;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;
   localparam int PC_INC = 4;
endpackage

// File: rtl/next_pc_gen.sv
// Next-PC selection: jump target, taken branch, or sequential.
import fetch_pkg::*;

module next_pc_gen #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc_plus4,
   input  logic [31:0]       instr,
   input  logic              jump,
   input  logic              branch,
   input  logic              alu_zero,
   output logic [ADDR_W-1:0] next_pc
);
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] br_off;
   logic [15:0]       imm;
   logic              unused_opc;

   assign imm        = instr[IMM_HI:IMM_LO];
   assign jump_tgt   = {pc_plus4[ADDR_W-1:28], instr[JT_HI:JT_LO], 2'b00};
   assign br_off     = {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
   assign unused_opc = ^instr[OPC_HI:OPC_LO];

   always_comb begin
      next_pc = pc_plus4;
      if (jump)                  next_pc = jump_tgt;
      else if (branch && alu_zero) next_pc = pc_plus4 + br_off;
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC/IR registers, imem req/ack handshake, timeout to a sticky error state.
import fetch_pkg::*;

module instruction_fetch_unit #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int                 TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus4,
   input  logic              exec_done,
   input  logic              jump,
   input  logic              branch,
   input  logic              alu_zero,
   output logic              fetch_err
);
   localparam logic [ADDR_W-1:0] RESET_PC_A = {RESET_PC[ADDR_W-1:2], 2'b00};
   localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT - 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] next_pc;

   assign pc_plus4 = pc_q + ADDR_W'(PC_INC);

   next_pc_gen #(.ADDR_W(ADDR_W)) u_next_pc (
      .pc_plus4 (pc_plus4),
      .instr    (instr_q),
      .jump     (jump),
      .branch   (branch),
      .alu_zero (alu_zero),
      .next_pc  (next_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (imem_ack)             state_d = EXEC;
            else if (cnt_q == TO_LAST) state_d = ERROR;
         end
         EXEC:  if (exec_done) state_d = FETCH;
         ERROR: state_d = ERROR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      if (state_q == FETCH) begin
         if (imem_ack) begin
            instr_d = imem_rdata;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (state_q == EXEC && exec_done) begin
         // low bits masked so alignment survives any target arithmetic
         pc_d = {next_pc[ADDR_W-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC_A;
         instr_q <= '0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      imem_req    = (state_q == FETCH);
      instr_valid = (state_q == EXEC);
      fetch_err   = (state_q == ERROR);
      imem_addr   = pc_q;
      pc          = pc_q;
      instr       = instr_q;
      opcode      = instr_q[OPC_HI:OPC_LO];
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench: directed program of fetches, timeout, and reset during EXEC.
module tb_instruction_fetch_unit;
   localparam int NV = 11;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, instr_valid, exec_done, jump, branch, alu_zero, fetch_err;
   logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4;
   logic [5:0]  opcode;

   int n_cmp = 0;
   int n_bad = 0;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [31:0] va[NV], vd[NV];
   int          vj[NV], vb[NV], vz[NV], vw[NV], vh[NV];

   bit          run = 0;
   bit          have_cur = 0;
   int          fidx = 0, cur_i = 0, wcnt = 0, ecnt = 0, cyc = 0, last_ack = 0;
   logic        man_ack = 0, man_ed = 0, man_j = 0;
   logic [31:0] man_rdata = '0;

   instruction_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
      .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .exec_done(exec_done),
      .jump(jump), .branch(branch), .alu_zero(alu_zero), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder, datapath stand-in and monitor; all driving happens here on negedge.
   always @(negedge clk) begin
      cyc++;
      if (!run) begin
         imem_ack   = man_ack;
         imem_rdata = man_rdata;
         exec_done  = man_ed;
         jump       = man_j;
         branch     = 1'b0;
         alu_zero   = 1'b0;
      end else begin
         if (imem_ack) begin
            if (exp_q.size() == 0) chk("queue_underflow", 32'(exp_q.size()), 32'd1);
            else begin
               cur = exp_q.pop_front();
               have_cur = 1;
            end
            cur_i = fidx;
            fidx++;
            wcnt = 0;
            ecnt = 0;
         end
         imem_ack = 1'b0;
         if (instr_valid && have_cur) begin
            chk("exec_pc", pc, cur.addr);
            chk("exec_instr", instr, cur.word);
            chk("exec_opcode", 32'(opcode), 32'(cur.word[31:26]));
            chk("exec_pc_plus4", pc_plus4, cur.addr + 32'd4);
            if (ecnt < vh[cur_i]) begin
               exec_done = 1'b0;
               jump = 1'($urandom); branch = 1'($urandom); alu_zero = 1'($urandom);
               ecnt++;
            end else begin
               exec_done = 1'b1;
               jump = 1'(vj[cur_i]); branch = 1'(vb[cur_i]); alu_zero = 1'(vz[cur_i]);
            end
         end else begin
            exec_done = 1'($urandom);
            jump = 1'($urandom); branch = 1'($urandom); alu_zero = 1'($urandom);
         end
         if (imem_req && fidx < NV && exp_q.size() > 0) begin
            chk("fetch_addr", imem_addr, exp_q[0].addr);
            if (wcnt < vw[fidx]) wcnt++;
            else begin
               imem_ack   = 1'b1;
               imem_rdata = vd[fidx];
               if (fidx > 0 && vw[fidx] == 0 && vh[fidx-1] == 0)
                  chk("fetch_interval", 32'(cyc - last_ack), 32'd2);
               last_ack = cyc;
            end
         end
      end
   end

   initial begin
      int nreq;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc4", pc_plus4, 32'h4);
      chk("rst_instr", instr, 32'h0);
      chk("rst_opcode", 32'(opcode), 32'd0);

      va = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h100, 32'h200, 32'h1FC, 32'h200, 32'h204, 32'hFFFF_FFFC, 32'h0};
      vd = '{32'h0, 32'h0, 32'h0800_0040, 32'h0800_0040, 32'h0800_0080, 32'h1000_FFFE,
             32'h0800_0080, 32'h1000_FFFE, 32'h1000_FF7D, 32'h0, 32'h0};
      vj = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
      vb = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0};
      vz = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
      vw = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0};
      vh = '{0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0};
      for (int i = 0; i < NV; i++) exp_q.push_back('{addr: va[i], word: vd[i]});
      run = 1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 400 && fidx < NV; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("prog_fetches", 32'(fidx), 32'(NV));
      chk("prog_queue_empty", 32'(exp_q.size()), 32'd0);

      // Timeout: memory never acknowledges.
      run = 0;
      man_ack = 0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("to_err_after_rst", 32'(fetch_err), 32'd0);
      rst_n = 1'b1;
      nreq = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (imem_req) nreq++;
         if (nreq > 0 && !imem_req) break;
      end
      chk("to_req_cycles", 32'(nreq), 32'd15);
      chk("to_fetch_err", 32'(fetch_err), 32'd1);
      chk("to_req_low", 32'(imem_req), 32'd0);
      repeat (20) @(negedge clk);
      chk("to_err_sticky", 32'(fetch_err), 32'd1);
      chk("to_req_stays_low", 32'(imem_req), 32'd0);

      // Reset while in EXEC with a jump retiring and a stray ack.
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req) begin nreq = 1; break; end
      end
      chk("rx_req_seen", 32'(nreq), 32'd1);
      @(posedge clk); #1;
      man_ack = 1; man_rdata = 32'h0800_0040;
      @(posedge clk); #1;
      chk("rx_in_exec", 32'(instr_valid), 32'd1);
      chk("rx_opcode", 32'(opcode), 32'd2);
      man_ed = 1; man_j = 1; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rx_pc", pc, 32'h0);
      chk("rx_valid", 32'(instr_valid), 32'd0);
      chk("rx_req", 32'(imem_req), 32'd0);
      chk("rx_instr", instr, 32'h0);
      man_ack = 0; man_ed = 0; man_j = 0; rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage directly upstream of the control unit in the single-cycle datapath. Holds the program counter, requests instruction words from instruction memory over a req/ack handshake, and latches each word into an instruction register. It presents the opcode field to the control unit and computes the next PC from the jump/branch/zero results returned by the datapath. A timeout counter flags a memory that never acknowledges.

## Interface
- ADDR_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] ignored and forced to 0
- TIMEOUT, 15, max cycles in FETCH without imem_ack before error; legal range 1..255
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  ADDR_W  fetch address, equals pc
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored outside FETCH
- imem_rdata  in  32  instruction word, sampled only when imem_req && imem_ack
- instr  out  32  instruction register
- opcode  out  6  instr[31:26], drives the control unit's instruction input
- instr_valid  out  1  high in EXEC only
- pc  out  ADDR_W  address of instruction in instr
- pc_plus4  out  ADDR_W  pc + 4, modulo 2^ADDR_W
- exec_done  in  1  datapath retires current instruction; sampled in EXEC only
- jump  in  1  from control unit
- branch  in  1  from control unit
- alu_zero  in  1  ALU zero flag
- fetch_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, FETCH, EXEC, ERROR.
- IDLE: imem_req=0, instr_valid=0; next state FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, timeout counter<=0, next state EXEC. Without ack: counter increments; when counter==TIMEOUT-1 without ack, next state ERROR.
- EXEC: instr_valid=1. Without exec_done: hold all state. With exec_done: pc<=next_pc, next state FETCH.
- ERROR: imem_req=0, instr_valid=0, fetch_err=1; left only by reset.
- next_pc priority: jump → {pc_plus4[31:28], instr[25:0], 2'b00}; else branch && alu_zero → pc_plus4 + (sign_extend(instr[15:0]) << 2); else pc_plus4.
- All PC arithmetic wraps modulo 2^ADDR_W; pc[1:0] always 0.
- jump and branch both high: jump wins. branch with alu_zero=0: pc_plus4.
- jump/branch/alu_zero are don't-care unless EXEC && exec_done.

## Timing
- Reset (rst_n low at an edge): state=IDLE, pc=RESET_PC&~3, instr=0, counter=0, fetch_err=0; so imem_req=0, instr_valid=0, opcode=0, pc_plus4=RESET_PC+4.
- Reset mid-operation (any state) takes effect at that edge; an ack in the same cycle is discarded.
- First request: cycle after rst_n rises, plus one (IDLE→FETCH).
- Ack in the first FETCH cycle: instr valid next cycle; minimum 2 cycles per instruction (FETCH, EXEC) with zero-wait memory and exec_done held high.
- imem_addr stable for the entire FETCH residency.
- Timeout: with no ack, ERROR entered after exactly TIMEOUT cycles in FETCH; fetch_err high from the following cycle.
- Outputs pc, instr, opcode, pc_plus4 are registered or derived from registers only; no combinational path from inputs to outputs.

## Structure
- Shared package fetch_pkg: state enum (IDLE, FETCH, EXEC, ERROR), opcode field bounds 31:26, jump target field 25:0, immediate field 15:0, PC_INC=4.
- Sub-module next_pc_gen: combinational; inputs pc_plus4, instr, jump, branch, alu_zero; output next_pc.
- Top: FSM, PC/IR registers, timeout counter.

## Test plan
- Reset then zero-wait memory returning 32'h0000_0000 at 0x0, exec_done=1 → fetches at 0x0, 0x4, 0x8 on consecutive 2-cycle intervals; opcode=0.
- In EXEC at pc=0x0000_0100, instr=32'h0800_0040, jump=1, exec_done → next imem_addr=0x0000_0100.
- At pc=0x0000_0200, instr[15:0]=16'hFFFE, branch=1, alu_zero=1 → next fetch 0x0000_01FC; same with alu_zero=0 → 0x0000_0204.
- At pc=32'hFFFF_FFFC, no jump/branch → next fetch 0x0000_0000 (wrap).
- imem_ack never asserted, TIMEOUT=15 → imem_req high 15 cycles, then fetch_err=1, imem_req=0, held until rst_n low.
- rst_n low during EXEC with exec_done=1, jump=1 → pc=RESET_PC, state IDLE, instr_valid=0 next cycle.
